// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback arbiter slice: register index
// and data widths, source identifiers and the buffered writeback entry.
package wb_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  // "reg" is a keyword, so the destination index field is called idx.
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] val;
  } wb_entry_t;

endpackage

// File: rtl/wb_arb_if.sv
// Execute/memory-side handshakes and register-file writeback bus of wb_arb.
// The master modport is the producer/consumer side; slave is the arbiter.
interface wb_arb_if;
  import wb_pkg::*;

  logic          i_alu_valid;
  logic          o_alu_ready;
  logic [AW-1:0] i_alu_reg;
  logic [DW-1:0] i_alu_val;

  logic          i_lsu_valid;
  logic          o_lsu_ready;
  logic [AW-1:0] i_lsu_reg;
  logic [DW-1:0] i_lsu_val;

  logic          o_wb_en;
  logic [AW-1:0] o_wb_reg;
  logic [DW-1:0] o_wb_val;
  logic          o_busy;

  modport master (
    output i_alu_valid, i_alu_reg, i_alu_val,
    output i_lsu_valid, i_lsu_reg, i_lsu_val,
    input  o_alu_ready, o_lsu_ready,
    input  o_wb_en, o_wb_reg, o_wb_val, o_busy
  );

  modport slave (
    input  i_alu_valid, i_alu_reg, i_alu_val,
    input  i_lsu_valid, i_lsu_reg, i_lsu_val,
    output o_alu_ready, o_lsu_ready,
    output o_wb_en, o_wb_reg, o_wb_val, o_busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO: DEPTH entries (power of two, >= 2), count-based
// full/empty, pushes refused while full even if a pop happens that cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  wb_entry_t i_data,
  input  logic      i_pop,
  output wb_entry_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  wb_entry_t     mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign o_full  = (count == (PW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem[head];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never observed and the array maps to plain registers/RAM.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[tail] <= i_data;
  end

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: round-robin merge of ALU and LSU results into one
// registered register-file write port. Define WB_BYPASS_EN for read forwarding.
module wb_arb
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  wb_arb_if.slave       bus
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0] i_rd0_reg,
  input  logic [AW-1:0] i_rd1_reg,
  input  logic [DW-1:0] i_rf0_val,
  input  logic [DW-1:0] i_rf1_val,
  output logic [DW-1:0] o_rd0_val,
  output logic [DW-1:0] o_rd1_val
`endif
);

  wb_entry_t     alu_in, lsu_in;
  wb_entry_t     alu_head, lsu_head, pick;
  logic          alu_full, alu_empty, lsu_full, lsu_empty;
  logic          pop_alu, pop_lsu;
  wb_src_e       rr;
  logic          wb_en_q;
  logic [AW-1:0] wb_reg_q;
  logic [DW-1:0] wb_val_q;

  assign alu_in = '{idx: bus.i_alu_reg, val: bus.i_alu_val};
  assign lsu_in = '{idx: bus.i_lsu_reg, val: bus.i_lsu_val};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (bus.i_alu_valid),
    .i_data  (alu_in),
    .i_pop   (pop_alu),
    .o_data  (alu_head),
    .o_full  (alu_full),
    .o_empty (alu_empty)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (bus.i_lsu_valid),
    .i_data  (lsu_in),
    .i_pop   (pop_lsu),
    .o_data  (lsu_head),
    .o_full  (lsu_full),
    .o_empty (lsu_empty)
  );

  // Readiness comes from the registered counts only, never from this cycle's pop.
  assign bus.o_alu_ready = !alu_full;
  assign bus.o_lsu_ready = !lsu_full;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    pop_alu = 1'b0;
    pop_lsu = 1'b0;
    pick    = alu_head;
    if (!alu_empty && (lsu_empty || rr == SRC_ALU)) begin
      pop_alu = 1'b1;
    end else if (!lsu_empty) begin
      pop_lsu = 1'b1;
      pick    = lsu_head;
    end
  end

  // The pointer only moves on contention, handing priority to the loser.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr <= SRC_ALU;
    end else if (!alu_empty && !lsu_empty) begin
      rr <= pop_alu ? SRC_LSU : SRC_ALU;
    end
  end

  // Register-0 writes drain the FIFO but never strobe the register file.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_en_q  <= 1'b0;
      wb_reg_q <= '0;
      wb_val_q <= '0;
    end else begin
      wb_en_q <= (pop_alu || pop_lsu) && (pick.idx != '0);
      if (pop_alu || pop_lsu) begin
        wb_reg_q <= pick.idx;
        wb_val_q <= pick.val;
      end
    end
  end

  assign bus.o_wb_en  = wb_en_q;
  assign bus.o_wb_reg = wb_reg_q;
  assign bus.o_wb_val = wb_val_q;
  assign bus.o_busy   = !alu_empty || !lsu_empty || wb_en_q;

`ifdef WB_BYPASS_EN
  // Forward the pending write during the cycle before the register file commits it.
  assign o_rd0_val = (wb_en_q && wb_reg_q == i_rd0_reg) ? wb_val_q : i_rf0_val;
  assign o_rd1_val = (wb_en_q && wb_reg_q == i_rd1_reg) ? wb_val_q : i_rf1_val;
`endif

endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: directed scenarios plus randomized streams
// compared against a queue-based model of the writeback rules.
module tb_wb_arb;
  import wb_pkg::*;

  localparam int DEPTH = 2;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  wb_arb_if bus ();

`ifdef WB_BYPASS_EN
  logic [AW-1:0] i_rd0_reg = '0, i_rd1_reg = '0;
  logic [DW-1:0] i_rf0_val = '0, i_rf1_val = '0;
  logic [DW-1:0] o_rd0_val, o_rd1_val;
`endif

  wb_arb #(.DEPTH(DEPTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
`ifdef WB_BYPASS_EN
    ,
    .i_rd0_reg (i_rd0_reg),
    .i_rd1_reg (i_rd1_reg),
    .i_rf0_val (i_rf0_val),
    .i_rf1_val (i_rf1_val),
    .o_rd0_val (o_rd0_val),
    .o_rd1_val (o_rd1_val)
`endif
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per source plus the round-robin preference.
  wb_entry_t     q_alu[$], q_lsu[$];
  bit            m_rr;
  logic          exp_en;
  logic [AW-1:0] exp_reg;
  logic [DW-1:0] exp_val;

  // Stream bookkeeping.
  wb_entry_t   a_src[$], l_src[$];
  wb_entry_t   d_log[$], m_log[$];
  logic [1:0]  d_rdy[$], m_rdy[$];
  bit          bp_a, bp_l, timed_out;

  task automatic model_reset();
    q_alu.delete();
    q_lsu.delete();
    m_rr    = 1'b0;
    exp_en  = 1'b0;
    exp_reg = '0;
    exp_val = '0;
  endtask

  task automatic idle_inputs();
    bus.i_alu_valid = 1'b0;
    bus.i_alu_reg   = '0;
    bus.i_alu_val   = '0;
    bus.i_lsu_valid = 1'b0;
    bus.i_lsu_reg   = '0;
    bus.i_lsu_val   = '0;
  endtask

  // One clock: model decides transfers from pre-edge state, then the edge,
  // then expected outputs become visible 1 time unit after the edge.
  task automatic tick();
    bit pa, pl, a_ne, l_ne, have;
    wb_entry_t pe, ea, el;
    pa   = bus.i_alu_valid && (q_alu.size() < DEPTH);
    pl   = bus.i_lsu_valid && (q_lsu.size() < DEPTH);
    ea.idx = bus.i_alu_reg; ea.val = bus.i_alu_val;
    el.idx = bus.i_lsu_reg; el.val = bus.i_lsu_val;
    a_ne = q_alu.size() != 0;
    l_ne = q_lsu.size() != 0;
    have = a_ne || l_ne;
    pe   = '0;
    if (a_ne && (!l_ne || !m_rr)) pe = q_alu.pop_front();
    else if (l_ne)                pe = q_lsu.pop_front();
    if (a_ne && l_ne) m_rr = !m_rr;
    if (pa) q_alu.push_back(ea);
    if (pl) q_lsu.push_back(el);
    @(posedge i_clk);
    #1;
    exp_en = have && (pe.idx != '0);
    if (have) begin
      exp_reg = pe.idx;
      exp_val = pe.val;
    end
    if (exp_en) m_log.push_back(pe);
  endtask

  // Drives a_src/l_src with the real valid/ready protocol and records what the
  // DUT writes and advertises; comparisons are left to the calling test.
  task automatic stream(input bit throttle, input int max_cyc);
    int ia, il;
    bit acc_a, acc_l, done;
    wb_entry_t e;
    d_log.delete(); m_log.delete(); d_rdy.delete(); m_rdy.delete();
    bp_a = 0; bp_l = 0; timed_out = 0; done = 0;
    ia = 0; il = 0;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      bus.i_alu_valid = (ia < a_src.size()) && (!throttle || $urandom_range(0, 3) != 0);
      bus.i_lsu_valid = (il < l_src.size()) && (!throttle || $urandom_range(0, 3) != 0);
      if (ia < a_src.size()) begin bus.i_alu_reg = a_src[ia].idx; bus.i_alu_val = a_src[ia].val; end
      if (il < l_src.size()) begin bus.i_lsu_reg = l_src[il].idx; bus.i_lsu_val = l_src[il].val; end
      d_rdy.push_back({bus.o_alu_ready, bus.o_lsu_ready});
      m_rdy.push_back({q_alu.size() < DEPTH, q_lsu.size() < DEPTH});
      if (bus.o_alu_ready !== 1'b1) bp_a = 1;
      if (bus.o_lsu_ready !== 1'b1) bp_l = 1;
      acc_a = bus.i_alu_valid && (bus.o_alu_ready === 1'b1);
      acc_l = bus.i_lsu_valid && (bus.o_lsu_ready === 1'b1);
      tick();
      if (bus.o_wb_en === 1'b1) begin
        e.idx = bus.o_wb_reg; e.val = bus.o_wb_val;
        d_log.push_back(e);
      end
      if (acc_a) ia++;
      if (acc_l) il++;
      done = (ia == a_src.size()) && (il == l_src.size()) &&
             (q_alu.size() == 0) && (q_lsu.size() == 0) && !exp_en;
    end
    timed_out = !done;
    idle_inputs();
  endtask

  function automatic int log_diffs();
    int n = 0;
    if (d_log.size() != m_log.size()) n++;
    for (int i = 0; i < d_log.size() && i < m_log.size(); i++)
      if (d_log[i] !== m_log[i]) n++;
    return n;
  endfunction

  function automatic int rdy_diffs();
    int n = 0;
    for (int i = 0; i < d_rdy.size(); i++)
      if (d_rdy[i] !== m_rdy[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #2;
    checks++;
    if (bus.o_wb_en !== 1'b0 || bus.o_wb_reg !== '0 || bus.o_wb_val !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b reg=%0d val=%h, want 0/0/0", bus.o_wb_en, bus.o_wb_reg, bus.o_wb_val);
    end
    checks++;
    if (bus.o_alu_ready !== 1'b1 || bus.o_lsu_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got alu_rdy=%b lsu_rdy=%b busy=%b, want 1/1/0", bus.o_alu_ready, bus.o_lsu_ready, bus.o_busy);
    end
    #5 i_rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus.i_alu_valid = 1; bus.i_lsu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.i_alu_reg = AW'(3 + i); bus.i_alu_val = DW'(32'hA0 + i);
      bus.i_lsu_reg = AW'(16 + i); bus.i_lsu_val = DW'(32'hB0 + i);
      tick();
    end
    // Two ALU entries are buffered and a write is on the bus here.
    #2 i_rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.o_wb_en !== 1'b0 || bus.o_wb_reg !== '0 || bus.o_wb_val !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got en=%b reg=%0d val=%h, want 0/0/0", bus.o_wb_en, bus.o_wb_reg, bus.o_wb_val);
    end
    checks++;
    if (bus.o_alu_ready !== 1'b1 || bus.o_lsu_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_status: got alu_rdy=%b lsu_rdy=%b busy=%b, want 1/1/0", bus.o_alu_ready, bus.o_lsu_ready, bus.o_busy);
    end
    idle_inputs();
    #1 i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.o_wb_en !== 1'b0 || bus.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet[%0d]: got en=%b busy=%b, want 0/0", i, bus.o_wb_en, bus.o_busy);
      end
    end
  endtask

  task automatic test_single();
    bus.i_alu_valid = 1; bus.i_alu_reg = 5; bus.i_alu_val = 32'h1234;
    tick();
    idle_inputs();
    checks++;
    if (bus.o_wb_en !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_edge1: got en=%b busy=%b, want 0/1", bus.o_wb_en, bus.o_busy);
    end
    tick();
    checks++;
    if (bus.o_wb_en !== 1'b1 || bus.o_wb_reg !== 5'd5 || bus.o_wb_val !== 32'h1234) begin
      errors++;
      $display("FAIL single_edge2: got en=%b reg=%0d val=%h, want 1/5/1234", bus.o_wb_en, bus.o_wb_reg, bus.o_wb_val);
    end
    tick();
    checks++;
    if (bus.o_wb_en !== 1'b0 || bus.o_wb_reg !== 5'd5 || bus.o_wb_val !== 32'h1234 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_edge3: got en=%b reg=%0d val=%h busy=%b, want 0/5/1234/0", bus.o_wb_en, bus.o_wb_reg, bus.o_wb_val, bus.o_busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.i_alu_valid = 1;
    for (int i = 0; i < 6; i++) begin
      bus.i_alu_reg = AW'(1 + i); bus.i_alu_val = DW'(32'hC00 + i);
      if (i >= 4) bus.i_alu_valid = 0;
      tick();
      // Entries pushed at edges 1..4 appear after edges 2..5 with no gaps.
      checks++;
      if (bus.o_wb_en !== (i >= 1 && i <= 4) || (i >= 1 && i <= 4 && bus.o_wb_reg !== AW'(i))) begin
        errors++;
        $display("FAIL b2b[%0d]: got en=%b reg=%0d, want en=%b reg=%0d", i, bus.o_wb_en, bus.o_wb_reg, (i >= 1 && i <= 4), i);
      end
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    int exp_order[6] = '{1, 9, 2, 10, 3, 11};
    int bad = 0;
    wb_entry_t e;
    a_src.delete(); l_src.delete();
    for (int i = 0; i < 3; i++) begin
      e.idx = AW'(1 + i); e.val = DW'(32'h100 + i); a_src.push_back(e);
      e.idx = AW'(9 + i); e.val = DW'(32'h900 + i); l_src.push_back(e);
    end
    stream(1'b0, 40);
    checks++;
    if (timed_out) begin errors++; $display("FAIL contention_timeout: got no drain within 40 cycles, want drained"); end
    if (d_log.size() != 6) bad++;
    for (int i = 0; i < d_log.size() && i < 6; i++) if (d_log[i].idx !== AW'(exp_order[i])) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL contention_order: got %0d writes with %0d deviations, want order 1,9,2,10,3,11", d_log.size(), bad);
    end
    checks++;
    if (!bp_a || !bp_l) begin
      errors++;
      $display("FAIL contention_backpressure: got alu_bp=%b lsu_bp=%b, want 1/1", bp_a, bp_l);
    end
    checks++;
    if (rdy_diffs() != 0) begin errors++; $display("FAIL contention_ready: got %0d ready deviations, want 0", rdy_diffs()); end
  endtask

  // Runs right after contention, which leaves the LSU holding priority.
  task automatic test_full();
    int exp_order[5] = '{20, 12, 21, 13, 14};
    int bad = 0;
    wb_entry_t e;
    a_src.delete(); l_src.delete();
    for (int i = 0; i < 3; i++) begin e.idx = AW'(12 + i); e.val = DW'(32'hA000 + i); a_src.push_back(e); end
    for (int i = 0; i < 2; i++) begin e.idx = AW'(20 + i); e.val = DW'(32'hB000 + i); l_src.push_back(e); end
    stream(1'b0, 40);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout: got no drain within 40 cycles, want drained"); end
    if (d_log.size() != 5) bad++;
    for (int i = 0; i < d_log.size() && i < 5; i++) if (d_log[i].idx !== AW'(exp_order[i])) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_order: got %0d writes with %0d deviations, want 20,12,21,13,14 once each", d_log.size(), bad);
    end
    checks++;
    if (!bp_a) begin errors++; $display("FAIL full_alu_ready: got no ready drop, want drop with 2 buffered"); end
    checks++;
    if (log_diffs() != 0 || rdy_diffs() != 0) begin
      errors++;
      $display("FAIL full_model: got %0d data and %0d ready deviations, want 0/0", log_diffs(), rdy_diffs());
    end
  endtask

  task automatic test_reg0();
    bus.i_alu_valid = 1; bus.i_alu_reg = 0; bus.i_alu_val = 32'hDEAD;
    tick();
    idle_inputs();
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL reg0_busy_before: got %b want 1", bus.o_busy); end
    tick();
    checks++;
    if (bus.o_wb_en !== 1'b0 || bus.o_wb_reg !== '0 || bus.o_wb_val !== 32'hDEAD) begin
      errors++;
      $display("FAIL reg0_write: got en=%b reg=%0d val=%h, want 0/0/dead", bus.o_wb_en, bus.o_wb_reg, bus.o_wb_val);
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reg0_busy_after: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_random();
    wb_entry_t e;
    for (int r = 0; r < 4; r++) begin
      a_src.delete(); l_src.delete();
      for (int i = 0; i < 30; i++) begin
        e.idx = AW'($urandom_range(0, 31)); e.val = $urandom; a_src.push_back(e);
        e.idx = AW'($urandom_range(0, 31)); e.val = $urandom; l_src.push_back(e);
      end
      stream(r[0], 400);
      checks++;
      if (timed_out) begin errors++; $display("FAIL random_timeout[%0d]: got no drain within 400 cycles, want drained", r); end
      checks++;
      if (log_diffs() != 0) begin
        errors++;
        $display("FAIL random_writes[%0d]: got %0d writes with %0d deviations, want %0d matching", r, d_log.size(), log_diffs(), m_log.size());
      end
      checks++;
      if (rdy_diffs() != 0) begin errors++; $display("FAIL random_ready[%0d]: got %0d ready deviations, want 0", r, rdy_diffs()); end
      checks++;
      if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL random_idle[%0d]: got busy=%b want 0", r, bus.o_busy); end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    bus.i_alu_valid = 1; bus.i_alu_reg = 7; bus.i_alu_val = 32'hBEEF;
    tick();
    idle_inputs();
    tick();
    i_rd0_reg = 7; i_rf0_val = '0; i_rd1_reg = 8; i_rf1_val = 32'h5555_0001;
    #1;
    checks++;
    if (o_rd0_val !== 32'hBEEF) begin errors++; $display("FAIL bypass_hit: got %h want beef", o_rd0_val); end
    checks++;
    if (o_rd1_val !== 32'h5555_0001) begin errors++; $display("FAIL bypass_miss: got %h want 55550001", o_rd1_val); end
    tick();
    #1;
    checks++;
    if (o_rd0_val !== '0) begin errors++; $display("FAIL bypass_idle: got %h want 0", o_rd0_val); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_full();
    test_reg0();
    test_reset_mid();
    test_random();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion by 300000, want earlier finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
